// File: rtl/dsc_pkg.sv
// Shared types and sizing helpers for the deterministic stochastic-computing multiplier.
package dsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dsc_state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int RUN_LEN       = 2**(2*DEFAULT_WIDTH);

  function automatic int prod_width(input int w);
    return 2*w;
  endfunction

  function automatic int run_len(input int w);
    return 2**(2*w);
  endfunction

endpackage

// File: rtl/dsc_b2s.sv
// Binary-to-stochastic generator: wrapping up-counter compared against a held threshold.
module dsc_b2s #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] thr,
  output logic             wrap,
  output logic             bit_out
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + WIDTH'(1);
  end

  assign wrap    = &cnt;
  assign bit_out = (thr > cnt);

endmodule

// File: rtl/dsc_mul_seq.sv
// Handshaked DSC multiplier: two unary streams ANDed and counted back into an exact product.
//
// state   | meaning
// IDLE    | waiting for start; operands latched and counters cleared on accept
// RUN     | streaming all 2^(2W) counter pairs, accumulating the AND stream
// DONE    | one-cycle done pulse with y valid, then back to IDLE
module dsc_mul_seq
  import dsc_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         busy,
  output logic                         done,
  output logic [prod_width(WIDTH)-1:0] y,
  output logic                         sn_y
);

  localparam int PW = prod_width(WIDTH);

  dsc_state_t state, state_nx;

  logic [WIDTH-1:0] a_r, b_r;
  logic [PW-1:0]    acc;
  logic             wrap_a, wrap_b;
  logic             bit_a, bit_b;
  logic             zero_op;
  logic             run, clr, y_load, y_zero;

  assign zero_op = (a == '0) || (b == '0);

  dsc_b2s #(.WIDTH(WIDTH)) u_gen_a (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .en      (run),
    .thr     (a_r),
    .wrap    (wrap_a),
    .bit_out (bit_a)
  );

  // B steps once per full sweep of A, so every (ca, cb) pair is visited exactly once.
  dsc_b2s #(.WIDTH(WIDTH)) u_gen_b (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .en      (run & wrap_a),
    .thr     (b_r),
    .wrap    (wrap_b),
    .bit_out (bit_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start)
          state_nx = ((EARLY_EXIT != 0) && zero_op) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (abort)
          state_nx = ST_IDLE;
        else if (wrap_a && wrap_b)
          state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    run    = 1'b0;
    clr    = 1'b0;
    y_load = 1'b0;
    y_zero = 1'b0;
    case (state)
      ST_IDLE: begin
        clr    = start;
        y_zero = start && (EARLY_EXIT != 0) && zero_op;
      end
      ST_RUN: begin
        run    = 1'b1;
        y_load = !abort && wrap_a && wrap_b;
      end
      default: ;
    endcase
    sn_y = run & bit_a & bit_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
    end else if (clr) begin
      a_r <= a;
      b_r <= b;
    end
  end

  // Peak count is (2^W-1)^2, which always fits in 2W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (run)
      acc <= acc + PW'(sn_y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      if (y_zero)
        y <= '0;
      else if (y_load)
        y <= acc + PW'(sn_y);
      busy <= (state_nx != ST_IDLE);
      done <= (state_nx == ST_DONE);
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Randomised self-checking bench for dsc_mul_seq at W=3, W=4 (with and without early exit) and W=8.
module tb_dsc_mul_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance index: 0 = W4 early-exit, 1 = W4 no early-exit, 2 = W8, 3 = W3.
  logic       start_i [4];
  logic       abort_i [4];
  logic [7:0] a_i     [4];
  logic [7:0] b_i     [4];
  logic       busy_o  [4];
  logic       done_o  [4];
  logic       sny_o   [4];
  logic [7:0]  y0, y1;
  logic [15:0] y2;
  logic [5:0]  y3;

  int checks   = 0;
  int failures = 0;

  dsc_mul_seq #(.WIDTH(4), .EARLY_EXIT(1)) dut_w4 (
    .clk(clk), .rst(rst), .start(start_i[0]), .abort(abort_i[0]),
    .a(a_i[0][3:0]), .b(b_i[0][3:0]),
    .busy(busy_o[0]), .done(done_o[0]), .y(y0), .sn_y(sny_o[0]));

  dsc_mul_seq #(.WIDTH(4), .EARLY_EXIT(0)) dut_w4n (
    .clk(clk), .rst(rst), .start(start_i[1]), .abort(abort_i[1]),
    .a(a_i[1][3:0]), .b(b_i[1][3:0]),
    .busy(busy_o[1]), .done(done_o[1]), .y(y1), .sn_y(sny_o[1]));

  dsc_mul_seq #(.WIDTH(8), .EARLY_EXIT(1)) dut_w8 (
    .clk(clk), .rst(rst), .start(start_i[2]), .abort(abort_i[2]),
    .a(a_i[2]), .b(b_i[2]),
    .busy(busy_o[2]), .done(done_o[2]), .y(y2), .sn_y(sny_o[2]));

  dsc_mul_seq #(.WIDTH(3), .EARLY_EXIT(1)) dut_w3 (
    .clk(clk), .rst(rst), .start(start_i[3]), .abort(abort_i[3]),
    .a(a_i[3][2:0]), .b(b_i[3][2:0]),
    .busy(busy_o[3]), .done(done_o[3]), .y(y3), .sn_y(sny_o[3]));

  function automatic longint get_y(input int s);
    case (s)
      0:       return longint'(y0);
      1:       return longint'(y1);
      2:       return longint'(y2);
      default: return longint'(y3);
    endcase
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive operands with start held across 'holds' edges (2 when issued from a done cycle).
  task automatic issue(input int s, input int ta, input int tb, input int holds);
    a_i[s]     = 8'(ta);
    b_i[s]     = 8'(tb);
    start_i[s] = 1'b1;
    repeat (holds) tick();
    start_i[s] = 1'b0;
  endtask

  // Called right after the accepting edge; returns in the done cycle.
  // poke >= 0 raises start with other operands at that cycle of the run.
  task automatic wait_done(input int s, input int w, input bit ee, input int ta, input int tb,
                           input int poke, input string tag);
    longint exp_y;
    int     lat, n, pop, gaps;
    exp_y = longint'(ta) * longint'(tb);
    lat   = (ee && (ta == 0 || tb == 0)) ? 0 : 2**(2*w);
    n = 0; pop = 0; gaps = 0;
    while (!done_o[s] && n < lat + 8) begin
      pop += int'(sny_o[s]);
      if (!busy_o[s]) gaps++;
      if (n == poke) begin
        a_i[s] = 8'hff;
        b_i[s] = 8'h01;
        start_i[s] = 1'b1;
      end else begin
        start_i[s] = 1'b0;
      end
      tick();
      n++;
    end
    start_i[s] = 1'b0;
    check({tag, "_lat"},  n, lat);
    check({tag, "_y"},    get_y(s), exp_y);
    check({tag, "_pop"},  pop, exp_y);
    check({tag, "_busy"}, gaps, 0);
    check({tag, "_busy_done"}, busy_o[s], 1);
  endtask

  task automatic after_done(input int s, input string tag);
    tick();
    check({tag, "_done_pulse"}, done_o[s], 0);
    check({tag, "_idle"}, busy_o[s], 0);
  endtask

  task automatic count_done(input int s, input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      tick();
      seen += int'(done_o[s]);
    end
  endtask

  initial begin
    int seen, ta, tb, na, nb;
    for (int i = 0; i < 4; i++) begin
      start_i[i] = 1'b0; abort_i[i] = 1'b0; a_i[i] = '0; b_i[i] = '0;
    end
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_busy%0d", i), busy_o[i], 0);
      check($sformatf("rst_done%0d", i), done_o[i], 0);
      check($sformatf("rst_y%0d", i), get_y(i), 0);
      check($sformatf("rst_sny%0d", i), sny_o[i], 0);
    end
    rst = 1'b0;
    tick();

    // Asynchronous reset in the middle of a run.
    issue(0, 5, 7, 1);
    repeat (99) tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", busy_o[0], 0);
    check("midrst_done", done_o[0], 0);
    check("midrst_y", get_y(0), 0);
    check("midrst_sny", sny_o[0], 0);
    tick();
    rst = 1'b0;
    count_done(0, 300, seen);
    check("midrst_no_done", seen, 0);

    issue(0, 5, 7, 1);
    wait_done(0, 4, 1'b1, 5, 7, -1, "basic");
    after_done(0, "basic");

    // Full scale with an ignored start in the middle of the run.
    issue(0, 15, 15, 1);
    wait_done(0, 4, 1'b1, 15, 15, 40, "full4");
    after_done(0, "full4");

    // Abort mid-run, again with a stray start before it.
    issue(0, 3, 4, 1);
    repeat (29) tick();
    a_i[0] = 8'd9; b_i[0] = 8'd9; start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    repeat (19) tick();
    abort_i[0] = 1'b1;
    tick();
    abort_i[0] = 1'b0;
    check("abort_busy", busy_o[0], 0);
    check("abort_y", get_y(0), 225);
    count_done(0, 300, seen);
    check("abort_no_done", seen, 0);
    check("abort_y_hold", get_y(0), 225);

    // Abort in the final run cycle beats completion.
    issue(0, 3, 4, 1);
    repeat (255) tick();
    abort_i[0] = 1'b1;
    tick();
    abort_i[0] = 1'b0;
    check("abort_last_done", done_o[0], 0);
    check("abort_last_busy", busy_o[0], 0);
    check("abort_last_y", get_y(0), 225);

    issue(0, 0, 9, 1);
    wait_done(0, 4, 1'b1, 0, 9, -1, "early");
    after_done(0, "early");

    issue(1, 0, 9, 1);
    wait_done(1, 4, 1'b0, 0, 9, -1, "noearly");
    after_done(1, "noearly");

    for (int k = 0; k < 12; k++) begin
      ta = int'($urandom_range(0, 15));
      tb = int'($urandom_range(0, 15));
      issue(0, ta, tb, 1);
      wait_done(0, 4, 1'b1, ta, tb, -1, $sformatf("rnd%0d", k));
      after_done(0, $sformatf("rnd%0d", k));
    end

    issue(2, 255, 255, 1);
    wait_done(2, 8, 1'b1, 255, 255, -1, "full8");
    after_done(2, "full8");

    // Exhaustive W=3 sweep, each start raised in the previous done cycle.
    issue(3, 0, 0, 1);
    for (int k = 0; k < 64; k++) begin
      ta = k / 8;
      tb = k % 8;
      wait_done(3, 3, 1'b1, ta, tb, -1, $sformatf("sweep_%0d_%0d", ta, tb));
      if (k < 63) begin
        na = (k + 1) / 8;
        nb = (k + 1) % 8;
        issue(3, na, nb, 2);
      end
    end
    after_done(3, "sweep_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
